keypad_event_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_frame_debounce.sv | 49 ++++
 rtl/keypad_event_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_event_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and key-map helpers for the 3x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_COLS  = 3;
    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned NUM_KEYS  = NUM_COLS * NUM_ROWS;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned COL_IDX_W = 2;

    localparam logic [CODE_W-1:0] KEY_NONE  = 4'hF;
    localparam logic [CODE_W-1:0] KEY_MULTI = 4'hE;
    localparam logic [CODE_W-1:0] KEY_STAR  = 4'd10;
    localparam logic [CODE_W-1:0] KEY_HASH  = 4'd11;

    // Phone layout: rows 0..2 hold digits 1..9, bottom row is '*', '0', '#'.
    function automatic logic [CODE_W-1:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [CODE_W-1:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = CODE_W'(row) * 4'd3 + CODE_W'(col) + 4'd1;
        end
        return code;
    endfunction

    function automatic logic is_key(input logic [CODE_W-1:0] code);
        return code <= KEY_HASH;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debouncer: a code must repeat for DEBOUNCE_FRAMES frames before it becomes stable.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] frame_code,
    input  logic              frame_strobe,
    output logic              accept_c
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

    logic [CODE_W-1:0] candidate;
    logic [CODE_W-1:0] stable;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt_c;

    // After the update the candidate always equals frame_code, so compare that against stable.
    always_comb begin
        count_nxt_c = count;
        if (frame_code != candidate) begin
            count_nxt_c = CNT_W'(1);
        end else if (count >= CNT_MAX) begin
            count_nxt_c = CNT_MAX;
        end else begin
            count_nxt_c = count + CNT_W'(1);
        end
        accept_c = frame_strobe && (count_nxt_c >= CNT_MAX) && (frame_code != stable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            candidate <= KEY_NONE;
            stable    <= KEY_NONE;
            count     <= '0;
        end else if (frame_strobe) begin
            candidate <= frame_code;
            count     <= count_nxt_c;
            if (accept_c) begin
                stable <= frame_code;
            end
        end
    end

endmodule

// File: rtl/keypad_event_scanner.sv
// Keypad column scanner, frame accumulator and key event generator.
// Optional auto-repeat of held keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_event_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES     = 7,
    parameter int unsigned REPEAT_DELAY_FRAMES = 100,
    parameter int unsigned REPEAT_RATE_FRAMES  = 33
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] key_col,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_star_rise,
    output logic                key_held
);

    if (DEBOUNCE_FRAMES == 0 || DEBOUNCE_FRAMES > 15 ||
        REPEAT_DELAY_FRAMES == 0 || REPEAT_RATE_FRAMES == 0) begin : g_bad_params
        $error("keypad_event_scanner: parameter out of range");
    end

    logic [COL_IDX_W-1:0] col_idx;
    logic [NUM_KEYS-1:0]  acc;
    logic [NUM_KEYS-1:0]  frame_bits_c;
    logic [CODE_W-1:0]    frame_code_c;
    logic                 frame_strobe_c;
    logic                 accept_c;
    logic                 repeat_fire_c;
    logic [3:0]           hits;
    logic [CODE_W-1:0]    single_code;

    // Merge this cycle's row sample into the frame and classify the result.
    always_comb begin
        frame_bits_c = acc;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            frame_bits_c[r*NUM_COLS + int'(col_idx)] = key_row[r];
        end
        hits        = '0;
        single_code = KEY_NONE;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            for (int c = 0; c < int'(NUM_COLS); c++) begin
                if (frame_bits_c[r*NUM_COLS + c]) begin
                    hits        = hits + 4'd1;
                    single_code = key_map(2'(r), 2'(c));
                end
            end
        end
        if (hits == 4'd0) begin
            frame_code_c = KEY_NONE;
        end else if (hits == 4'd1) begin
            frame_code_c = single_code;
        end else begin
            frame_code_c = KEY_MULTI;
        end
        frame_strobe_c = (col_idx == COL_IDX_W'(NUM_COLS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx <= '0;
            key_col <= NUM_COLS'(1);
            acc     <= '0;
        end else if (frame_strobe_c) begin
            col_idx <= '0;
            key_col <= NUM_COLS'(1);
            acc     <= '0;
        end else begin
            col_idx <= col_idx + COL_IDX_W'(1);
            key_col <= {key_col[NUM_COLS-2:0], key_col[NUM_COLS-1]};
            acc     <= frame_bits_c;
        end
    end

    keypad_frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_code  (frame_code_c),
        .frame_strobe(frame_strobe_c),
        .accept_c    (accept_c)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                      REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;
    logic [REP_W-1:0] rep_target_c;

    // key_held mirrors "stable is a valid key", so it gates the repeat timer.
    always_comb begin
        rep_target_c  = rep_armed ? REP_W'(REPEAT_RATE_FRAMES) : REP_W'(REPEAT_DELAY_FRAMES);
        repeat_fire_c = frame_strobe_c && key_held && !accept_c &&
                        ((rep_cnt + REP_W'(1)) == rep_target_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (accept_c) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (frame_strobe_c && key_held) begin
            if (repeat_fire_c) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end
`else
    assign repeat_fire_c = 1'b0;
`endif

    // Events are registered so they appear for exactly the cycle after stable changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid     <= 1'b0;
            key_star_rise <= 1'b0;
            key_held      <= 1'b0;
            key_code      <= KEY_NONE;
        end else begin
            key_valid     <= 1'b0;
            key_star_rise <= 1'b0;
            if (accept_c) begin
                key_held <= is_key(frame_code_c);
                if (is_key(frame_code_c)) begin
                    key_valid     <= 1'b1;
                    key_code      <= frame_code_c;
                    key_star_rise <= (frame_code_c == KEY_STAR);
                end
            end else if (repeat_fire_c) begin
                key_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Scoreboard bench for keypad_event_scanner driving a modelled key matrix.
`timescale 1ns/1ps
module tb_keypad_event_scanner;

    localparam int unsigned DEB = 3;

    typedef struct packed {
        logic [3:0] code;
        logic       star;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  key_col;
    logic [3:0]  key_row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_star_rise;
    logic        key_held;
    logic [11:0] pressed;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Key at (row r, col c) connects column drive c to row sense r.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            key_row[r] = |(pressed[r*3 +: 3] & key_col);
        end
    end

    keypad_event_scanner #(
        .DEBOUNCE_FRAMES    (DEB),
        .REPEAT_DELAY_FRAMES(10),
        .REPEAT_RATE_FRAMES (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_col      (key_col),
        .key_row      (key_row),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_star_rise(key_star_rise),
        .key_held     (key_held)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] code, input logic star);
        exp_t e;
        e.code = code;
        e.star = star;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_pulse(output int n, input int budget);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!key_valid && n < budget);
    endtask

    task automatic align_col0();
        int n = 0;
        while (key_col != 3'b001 && n < 4) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_col"},   int'(key_col), 1);
        check({tag, "_valid"}, int'(key_valid), 0);
        check({tag, "_code"},  int'(key_code), 15);
        check({tag, "_held"},  int'(key_held), 0);
        check({tag, "_star"},  int'(key_star_rise), 0);
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (key_valid) begin
                    check("pulse_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pulse_code", int'(key_code), int'(e.code));
                        check("pulse_star", int'(key_star_rise), int'(e.star));
                    end
                end else if (key_star_rise) begin
                    check("star_without_valid", int'(key_star_rise), 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pressed = '0;
        rst     = 1'b1;
        tick(3);
        check_reset_vals("reset");
        rst = 1'b0;

        // Idle scan: column rotates one per clock, nothing accepted.
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            if (k <= 6) check("col_scan", int'(key_col), 1 << (k % 3));
        end
        check("idle_code", int'(key_code), 15);
        check("idle_held", int'(key_held), 0);

        // '*' held 30 frames: one pulse with star strobe, bounded latency.
        pressed[9] = 1'b1;
        expect_pulse(4'd10, 1'b1);
        wait_pulse(n, 12);
        check("star_latency", int'(key_valid), 1);
        tick(90);
        check("star_held", int'(key_held), 1);
        check("star_code", int'(key_code), 10);
        pressed[9] = 1'b0;
        tick(6);
        check("star_held_after_release", int'(key_held), 1);
        tick(6);
        check("star_released", int'(key_held), 0);
        wait_drain("star_single_pulse", 0);

        // '5' bouncing every frame never becomes stable.
        for (int i = 0; i < 20; i++) begin
            pressed[4] = ~pressed[4];
            tick(3);
            if (i % 5 == 4) check("bounce_held", int'(key_held), 0);
        end
        pressed[4] = 1'b0;
        tick(12);
        check("bounce_code", int'(key_code), 10);
        check("bounce_held_end", int'(key_held), 0);

        // Rollover '1' -> '1'+'9' -> '9' -> release.
        pressed[0] = 1'b1;
        expect_pulse(4'd1, 1'b0);
        wait_drain("press1", 15);
        tick(15);
        check("held1", int'(key_held), 1);
        check("code1", int'(key_code), 1);
        pressed[8] = 1'b1;
        tick(15);
        check("multi_held", int'(key_held), 0);
        check("multi_code", int'(key_code), 1);
        pressed[0] = 1'b0;
        expect_pulse(4'd9, 1'b0);
        wait_drain("press9", 15);
        tick(15);
        check("held9", int'(key_held), 1);
        check("code9", int'(key_code), 9);
        pressed[8] = 1'b0;
        tick(18);
        check("release9_held", int'(key_held), 0);
        check("release9_code", int'(key_code), 9);

        // Reset during second debounce frame of '#'.
        align_col0();
        pressed[11] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check_reset_vals("reset_mid");
        rst = 1'b0;
        expect_pulse(4'd11, 1'b0);
        wait_pulse(n, 20);
        check("hash_latency_after_reset", n, 9);
        check("hash_code", int'(key_code), 11);
        tick(15);
        pressed[11] = 1'b0;
        tick(15);
        check("hash_released", int'(key_held), 0);
        wait_drain("hash_single_pulse", 0);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Auto-repeat: +10 frames then every 5; star strobe only on the first.
        begin
            int gaps[5] = '{30, 15, 15, 15, 15};
            align_col0();
            pressed[9] = 1'b1;
            expect_pulse(4'd10, 1'b1);
            for (int i = 0; i < 5; i++) expect_pulse(4'd10, 1'b0);
            wait_pulse(n, 15);
            check("rep_first", int'(key_valid), 1);
            for (int i = 0; i < 5; i++) begin
                wait_pulse(n, 40);
                check("rep_gap", n, gaps[i]);
            end
            pressed[9] = 1'b0;
            tick(15);
            wait_drain("rep_drain", 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
